imem_loader: RTL

Boot-time loader directly upstream of the 64-word instruction memory.
- Accepts a byte stream from a host link (UART receiver or bench) and assembles big-endian 32-bit words.
- Writes the words sequentially into the imem write port.
- Holds the MIPS core in reset until a complete program with a valid checksum has been written, then releases it.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_word_asm.sv | 41 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// geometry constants, FSM state encoding and the frame-count decode.
package imem_loader_pkg;

  localparam int WORDS          = 64;
  localparam int AW             = 6;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // A zero count byte stands for a full memory image.
  function automatic logic [AW:0] frame_words(input logic [7:0] count_byte);
    if (count_byte[AW-1:0] == {AW{1'b0}}) begin
      frame_words = (AW+1)'(WORDS);
    end else begin
      frame_words = {1'b0, count_byte[AW-1:0]};
    end
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus imem write port and core-control status of the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_wa;
  logic [31:0]   imem_wd;
  logic          cpu_reset;
  logic          done;
  logic          error;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_wa, imem_wd, cpu_reset, done, error
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_wa, imem_wd, cpu_reset, done, error
  );

endinterface

// File: rtl/imem_loader_word_asm.sv
// Big-endian byte-to-word assembler with running XOR checksum of every byte shifted in.
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word_next,
  output logic        o_word_ready,
  output logic [7:0]  o_csum
);

  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic [7:0]  r_csum;

  // Shift register, byte index and checksum accumulator.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_shift <= 32'h0000_0000;
      r_idx   <= 2'd0;
      r_csum  <= 8'h00;
    end else if (i_valid) begin
      r_shift <= {r_shift[23:0], i_data};
      r_idx   <= r_idx + 2'd1;
      r_csum  <= r_csum ^ i_data;
    end else begin
      r_shift <= r_shift;
      r_idx   <= r_idx;
      r_csum  <= r_csum;
    end
  end

  // The word is complete in the same cycle its last byte is accepted.
  assign o_word_next  = {r_shift[23:0], i_data};
  assign o_word_ready = i_valid && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_csum       = r_csum;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses count/data/checksum frames from the host link, writes imem
// word by word and releases the MIPS core only after a good checksum.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  imem_loader_if.slave  bus
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_t      r_state, w_state_nxt;
  logic [AW:0] r_cnt, w_cnt_nxt;
  logic [AW:0] r_num, w_num_nxt;
  logic        r_rx_ready, w_rx_ready_nxt;
  logic        r_we, w_we_nxt;
  logic [31:0] r_wd, w_wd_nxt;
  logic        r_cpu_reset, w_cpu_reset_nxt;
  logic        r_done, w_done_nxt;
  logic        r_error, w_error_nxt;

  logic        w_accept;
  logic        w_asm_clr;
  logic        w_asm_valid;
  logic [31:0] w_word_next;
  logic        w_word_ready;
  logic [7:0]  w_csum;

  assign w_accept = bus.rx_valid && r_rx_ready;

  loader_word_asm u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clr        (w_asm_clr),
    .i_valid      (w_asm_valid),
    .i_data       (bus.rx_data),
    .o_word_next  (w_word_next),
    .o_word_ready (w_word_ready),
    .o_csum       (w_csum)
  );

  // Next-state and next-output decode; every output is derived from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_num_nxt   = r_num;
    w_we_nxt    = 1'b0;
    w_wd_nxt    = r_wd;
    w_asm_clr   = 1'b0;
    w_asm_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_num_nxt   = frame_words(bus.rx_data);
          w_cnt_nxt   = {(AW+1){1'b0}};
          w_asm_clr   = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_asm_valid = w_accept;
        // The counter stops on the last word so the address never wraps.
        if (r_we) begin
          if (r_cnt == (r_num - CNT_ONE)) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else if (w_word_ready) begin
          w_we_nxt = 1'b1;
          w_wd_nxt = w_word_next;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_CHECK: begin
        if (w_accept) begin
          if (bus.rx_data == w_csum) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      ST_ERR:  w_state_nxt = ST_ERR;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_rx_ready_nxt  = ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD) ||
                       (w_state_nxt == ST_CHECK)) && !w_we_nxt;
    w_cpu_reset_nxt = (w_state_nxt != ST_RUN);
    w_done_nxt      = (w_state_nxt == ST_RUN);
    w_error_nxt     = (w_state_nxt == ST_ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {(AW+1){1'b0}};
      r_num       <= {(AW+1){1'b0}};
      r_rx_ready  <= 1'b1;
      r_we        <= 1'b0;
      r_wd        <= 32'h0000_0000;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_num       <= w_num_nxt;
      r_rx_ready  <= w_rx_ready_nxt;
      r_we        <= w_we_nxt;
      r_wd        <= w_wd_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.imem_we   = r_we;
  assign bus.imem_wa   = r_cnt[AW-1:0];
  assign bus.imem_wd   = r_wd;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule
